// File: rtl/mmu_banked_pkg.sv
// Shared memory-map constants and FSM state type for the banked MMU.
package mmu_banked_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_N_SLV    = 4;
  localparam int unsigned DEF_BANK_W   = 4;
  localparam int unsigned DEF_WIN_LOG2 = 14;
  localparam int unsigned DEF_TIMEOUT  = 15;

  // Region bases are packed with index 0 in the least significant slot, ascending by index.
  localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE =
    {16'hC000, 16'h8000, 16'h1000, 16'h0000};
  localparam logic [DEF_ADDR_W-1:0] DEF_WIN_BASE  = 16'h4000;
  localparam logic [DEF_ADDR_W-1:0] DEF_BANK_ADDR = 16'hFF00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mmu_banked_decode.sv
// Combinational address decode: region hit (one-hot), unmapped, bank register, banked window.
module mmu_banked_decode
  import mmu_banked_pkg::*;
#(
  parameter int unsigned              ADDR_W    = DEF_ADDR_W,
  parameter int unsigned              N_SLV     = DEF_N_SLV,
  parameter logic [N_SLV*ADDR_W-1:0]  SLV_BASE  = DEF_SLV_BASE,
  parameter logic [ADDR_W-1:0]        WIN_BASE  = DEF_WIN_BASE,
  parameter int unsigned              WIN_LOG2  = DEF_WIN_LOG2,
  parameter logic [ADDR_W-1:0]        BANK_ADDR = DEF_BANK_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  hit_c,
  output logic              unmapped_c,
  output logic              is_bank_c,
  output logic              in_win_c
);

  logic [ADDR_W:0]   hi;
  logic [ADDR_W-1:0] lo;

  // Walk regions from the top down so each region's upper bound is the next base.
  always_comb begin
    hit_c      = '0;
    hi         = {1'b1, ADDR_W'(0)};
    lo         = '0;
    is_bank_c  = (addr == BANK_ADDR);
    unmapped_c = !is_bank_c && (addr < SLV_BASE[ADDR_W-1:0]);
    for (int i = N_SLV - 1; i >= 0; i--) begin
      lo = SLV_BASE[i*ADDR_W +: ADDR_W];
      if (!is_bank_c && ({1'b0, addr} >= {1'b0, lo}) && ({1'b0, addr} < hi)) begin
        hit_c[i] = 1'b1;
      end
      hi = {1'b0, lo};
    end
    in_win_c = (addr[ADDR_W-1:WIN_LOG2] == WIN_BASE[ADDR_W-1:WIN_LOG2]);
  end

endmodule

// File: rtl/mmu_banked.sv
// CPU-side MMU: region decode, banked-window translation, slave handshake with timeout.
module mmu_banked
  import mmu_banked_pkg::*;
#(
  parameter int unsigned              ADDR_W    = DEF_ADDR_W,
  parameter int unsigned              DATA_W    = DEF_DATA_W,
  parameter int unsigned              N_SLV     = DEF_N_SLV,
  parameter logic [N_SLV*ADDR_W-1:0]  SLV_BASE  = DEF_SLV_BASE,
  parameter int unsigned              BANK_W    = DEF_BANK_W,
  parameter logic [ADDR_W-1:0]        WIN_BASE  = DEF_WIN_BASE,
  parameter int unsigned              WIN_LOG2  = DEF_WIN_LOG2,
  parameter logic [ADDR_W-1:0]        BANK_ADDR = DEF_BANK_ADDR,
  parameter int unsigned              TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic                      cpu_we,
  input  logic [DATA_W-1:0]         cpu_do,
  output logic [DATA_W-1:0]         cpu_di,
  output logic                      cpu_ack,
  output logic                      cpu_err,
  output logic [N_SLV-1:0]          slv_sel,
  output logic [ADDR_W+BANK_W-1:0]  slv_addr,
  output logic                      slv_we,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic [N_SLV*DATA_W-1:0]   slv_rdata,
  input  logic [N_SLV-1:0]          slv_ready,
  output logic [BANK_W-1:0]         bank
);

  localparam int unsigned PA_W  = ADDR_W + BANK_W;
  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic [N_SLV-1:0]   hit_c;
  logic               unmapped_c;
  logic               is_bank_c;
  logic               in_win_c;
  logic [PA_W-1:0]    phys_c;
  logic               sel_ready_c;
  logic [DATA_W-1:0]  sel_rdata_c;

  mmu_banked_decode #(
    .ADDR_W    (ADDR_W),
    .N_SLV     (N_SLV),
    .SLV_BASE  (SLV_BASE),
    .WIN_BASE  (WIN_BASE),
    .WIN_LOG2  (WIN_LOG2),
    .BANK_ADDR (BANK_ADDR)
  ) u_decode (
    .addr       (cpu_addr),
    .hit_c      (hit_c),
    .unmapped_c (unmapped_c),
    .is_bank_c  (is_bank_c),
    .in_win_c   (in_win_c)
  );

  // Window accesses keep the in-window offset and take the bank as the upper physical bits.
  always_comb begin
    phys_c = in_win_c ? PA_W'({bank, cpu_addr[WIN_LOG2-1:0]}) : PA_W'(cpu_addr);
  end

  // Ready and read data are taken only from the currently selected slave.
  always_comb begin
    sel_ready_c = |(slv_ready & slv_sel);
    sel_rdata_c = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (slv_sel[i]) begin
        sel_rdata_c = sel_rdata_c | slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bank      <= '0;
      cpu_di    <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            if (is_bank_c) begin
              // Bank register is local: answered without touching any slave.
              if (cpu_we) begin
                bank <= cpu_do[BANK_W-1:0];
              end else begin
                cpu_di <= DATA_W'(bank);
              end
              cpu_ack <= 1'b1;
              state   <= ST_RESP;
            end else if (unmapped_c) begin
              cpu_di  <= '1;
              cpu_ack <= 1'b1;
              cpu_err <= 1'b1;
              state   <= ST_RESP;
            end else begin
              slv_sel   <= hit_c;
              slv_we    <= cpu_we;
              slv_addr  <= phys_c;
              slv_wdata <= cpu_do;
              cnt       <= '0;
              state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is checked first so it wins over an expiring timeout.
          if (sel_ready_c) begin
            if (!slv_we) begin
              cpu_di <= sel_rdata_c;
            end
            cpu_ack <= 1'b1;
            slv_sel <= '0;
            slv_we  <= 1'b0;
            state   <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            cpu_di  <= '1;
            cpu_ack <= 1'b1;
            cpu_err <= 1'b1;
            slv_sel <= '0;
            slv_we  <= 1'b0;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_banked.sv
// Bench for mmu_banked: directed vector table, hand sequences, and randomized accesses vs a reference model.
module tb_mmu_banked;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_ack;
  logic        cpu_err;
  logic [3:0]  slv_sel;
  logic [19:0] slv_addr;
  logic        slv_we;
  logic [7:0]  slv_wdata;
  logic [31:0] slv_rdata;
  logic [3:0]  slv_ready;
  logic [3:0]  bank;

  logic        cpu_req_a;
  logic [7:0]  cpu_di_a;
  logic        cpu_ack_a;
  logic        cpu_err_a;
  logic [3:0]  slv_sel_a;
  logic [19:0] slv_addr_a;
  logic        slv_we_a;
  logic [7:0]  slv_wdata_a;
  logic [3:0]  slv_ready_a;
  logic [3:0]  bank_a;

  int          n_chk;
  int          n_fail;
  int          lat_cur;
  int          acc_cyc;
  logic [7:0]  rd_seed;
  logic [3:0]  noise;
  logic [3:0]  bank_m;
  logic [7:0]  di_m;

  mmu_banked u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .slv_sel   (slv_sel),
    .slv_addr  (slv_addr),
    .slv_we    (slv_we),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready),
    .bank      (bank)
  );

  // Alternate map whose lowest region starts at 16'h1000, leaving 0..0FFF unmapped.
  mmu_banked #(.SLV_BASE(64'hC000_8000_2000_1000)) u_alt (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req_a),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di_a),
    .cpu_ack   (cpu_ack_a),
    .cpu_err   (cpu_err_a),
    .slv_sel   (slv_sel_a),
    .slv_addr  (slv_addr_a),
    .slv_we    (slv_we_a),
    .slv_wdata (slv_wdata_a),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready_a),
    .bank      (bank_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: selected slave answers after lat_cur wait cycles; unselected slaves toggle ready randomly.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cyc <= 0;
      noise   <= '0;
    end else begin
      acc_cyc <= (slv_sel == 4'b0) ? 0 : acc_cyc + 1;
      noise   <= 4'($urandom);
    end
  end

  always_comb begin
    slv_ready = noise & ~slv_sel;
    if (acc_cyc == lat_cur) slv_ready = slv_ready | slv_sel;
  end

  always_comb begin
    slv_rdata = '0;
    for (int j = 0; j < 4; j++) slv_rdata[j*8 +: 8] = rd_seed + 8'(j);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: region index by base table, -2 for the bank register, -1 for unmapped.
  function automatic int region(input logic [15:0] a);
    int bases[4] = '{'h0000, 'h1000, 'h8000, 'hC000};
    int r = -1;
    if (a == 16'hFF00) return -2;
    for (int i = 0; i < 4; i++) if (int'(a) >= bases[i]) r = i;
    return r;
  endfunction

  task automatic run_txn(input logic [15:0] a, input logic w, input logic [7:0] wd,
                         input int lat, input logic [7:0] seed,
                         input logic [3:0] e_sel, input logic [19:0] e_phys, input int e_lat,
                         input logic e_err, input logic [7:0] e_di, input logic [3:0] e_bank,
                         input logic chg, input logic [15:0] c_addr);
    int got = -1;
    lat_cur  = lat;
    rd_seed  = seed;
    cpu_addr = a;
    cpu_we   = w;
    cpu_do   = wd;
    cpu_req  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (chg && k == 2) begin
        cpu_addr = c_addr;
        cpu_we   = 1'b0;
        cpu_do   = 8'hEE;
      end
      if (cpu_ack) begin
        got = k;
        break;
      end
      if (k >= 1) begin
        chk("sel", 32'(slv_sel), 32'(e_sel));
        if (e_sel != 4'b0) begin
          chk("slv_addr", 32'(slv_addr), 32'(e_phys));
          chk("slv_we", 32'(slv_we), 32'(w));
          if (w && k == 1) chk("slv_wdata", 32'(slv_wdata), 32'(wd));
        end
      end
    end
    chk("latency", 32'(got), 32'(e_lat));
    if (got >= 0) begin
      chk("err", 32'(cpu_err), 32'(e_err));
      chk("cpu_di", 32'(cpu_di), 32'(e_di));
      chk("sel_resp", 32'(slv_sel), 32'd0);
      chk("bank", 32'(bank), 32'(e_bank));
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic run_alt(input logic [15:0] a, input logic w, input logic [3:0] e_sel,
                         input int e_lat, input logic e_err, input logic [7:0] e_di);
    int got = -1;
    cpu_addr  = a;
    cpu_we    = w;
    cpu_do    = 8'h5A;
    cpu_req_a = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cpu_ack_a) begin
        got = k;
        break;
      end
      if (k >= 1) begin
        chk("alt_sel", 32'(slv_sel_a), 32'(e_sel));
        chk("alt_we", 32'(slv_we_a), 32'(w && (e_sel != 4'b0)));
      end
    end
    chk("alt_latency", 32'(got), 32'(e_lat));
    if (got >= 0) begin
      chk("alt_err", 32'(cpu_err_a), 32'(e_err));
      chk("alt_di", 32'(cpu_di_a), 32'(e_di));
      chk("alt_sel_resp", 32'(slv_sel_a), 32'd0);
    end
    @(posedge clk);
    #1;
    cpu_req_a = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  seed;
    logic [3:0]  e_sel;
    logic [19:0] e_phys;
    int          e_lat;
    logic        e_err;
    logic [7:0]  e_di;
    logic [3:0]  e_bank;
  } vec_t;

  vec_t tbl[15];

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_req_a = 1'b0;
    cpu_addr  = '0;
    cpu_we    = 1'b0;
    cpu_do    = '0;
    lat_cur   = 99;
    rd_seed   = '0;
    slv_ready_a = '0;

    //            addr     we    wdata  lat seed   sel      phys       lat err   di     bank
    tbl[0]  = '{16'h1234, 1'b0, 8'h00, 0,  8'hA4, 4'b0010, 20'h01234, 2,  1'b0, 8'hA5, 4'h0};
    tbl[1]  = '{16'hFF00, 1'b1, 8'h03, 0,  8'h00, 4'b0000, 20'h00000, 1,  1'b0, 8'hA5, 4'h3};
    tbl[2]  = '{16'h4010, 1'b0, 8'h00, 1,  8'h10, 4'b0010, 20'h0C010, 3,  1'b0, 8'h11, 4'h3};
    tbl[3]  = '{16'hFF00, 1'b0, 8'h00, 0,  8'h00, 4'b0000, 20'h00000, 1,  1'b0, 8'h03, 4'h3};
    tbl[4]  = '{16'h9000, 1'b1, 8'h5E, 2,  8'h00, 4'b0100, 20'h09000, 4,  1'b0, 8'h03, 4'h3};
    tbl[5]  = '{16'h8000, 1'b0, 8'h00, 16, 8'h00, 4'b0100, 20'h08000, 17, 1'b1, 8'hFF, 4'h3};
    tbl[6]  = '{16'hBFFF, 1'b0, 8'h00, 15, 8'h20, 4'b0100, 20'h0BFFF, 17, 1'b0, 8'h22, 4'h3};
    tbl[7]  = '{16'h0FFF, 1'b0, 8'h00, 0,  8'h40, 4'b0001, 20'h00FFF, 2,  1'b0, 8'h40, 4'h3};
    tbl[8]  = '{16'hC000, 1'b0, 8'h00, 2,  8'h70, 4'b1000, 20'h0C000, 4,  1'b0, 8'h73, 4'h3};
    tbl[9]  = '{16'hFF00, 1'b1, 8'hF7, 0,  8'h00, 4'b0000, 20'h00000, 1,  1'b0, 8'h73, 4'h7};
    tbl[10] = '{16'h7FFF, 1'b0, 8'h00, 0,  8'h00, 4'b0010, 20'h1FFFF, 2,  1'b0, 8'h01, 4'h7};
    tbl[11] = '{16'h3FFF, 1'b0, 8'h00, 0,  8'h00, 4'b0010, 20'h03FFF, 2,  1'b0, 8'h01, 4'h7};
    tbl[12] = '{16'h4000, 1'b1, 8'hAB, 20, 8'h00, 4'b0010, 20'h1C000, 17, 1'b1, 8'hFF, 4'h7};
    tbl[13] = '{16'hFF00, 1'b0, 8'h00, 0,  8'h00, 4'b0000, 20'h00000, 1,  1'b0, 8'h07, 4'h7};
    tbl[14] = '{16'hFFFF, 1'b1, 8'h11, 1,  8'h00, 4'b1000, 20'h0FFFF, 3,  1'b0, 8'h07, 4'h7};

    repeat (3) @(negedge clk);
    chk("rst_di", 32'(cpu_di), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_sel", 32'(slv_sel), 32'd0);
    chk("rst_we", 32'(slv_we), 32'd0);
    chk("rst_addr", 32'(slv_addr), 32'd0);
    chk("rst_wdata", 32'(slv_wdata), 32'd0);
    chk("rst_bank", 32'(bank), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].lat, tbl[i].seed, tbl[i].e_sel,
              tbl[i].e_phys, tbl[i].e_lat, tbl[i].e_err, tbl[i].e_di, tbl[i].e_bank, 1'b0, 16'h0);
    end

    // Request changes while the access is in flight; the new one is only taken after RESP.
    run_txn(16'h5000, 1'b0, 8'h00, 3, 8'h30, 4'b0010, 20'h1D000, 5, 1'b0, 8'h31, 4'h7, 1'b1, 16'h2000);
    run_txn(16'h2000, 1'b0, 8'h00, 0, 8'h50, 4'b0010, 20'h02000, 2, 1'b0, 8'h51, 4'h7, 1'b0, 16'h0);

    // Reset in the middle of a never-answered access.
    lat_cur  = 99;
    cpu_addr = 16'h9000;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_sel", 32'(slv_sel), 32'(4'b0100));
    #2;
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("midrst_sel", 32'(slv_sel), 32'd0);
    chk("midrst_we", 32'(slv_we), 32'd0);
    chk("midrst_addr", 32'(slv_addr), 32'd0);
    chk("midrst_bank", 32'(bank), 32'd0);
    chk("midrst_di", 32'(cpu_di), 32'd0);
    @(negedge clk);
    chk("midrst_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_txn(16'h9000, 1'b0, 8'h00, 1, 8'h60, 4'b0100, 20'h09000, 3, 1'b0, 8'h62, 4'h0, 1'b0, 16'h0);
    bank_m = 4'h0;
    di_m   = 8'h62;

    // Randomized accesses against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      logic        w;
      logic [7:0]  wd;
      logic [7:0]  seed;
      int          lat;
      int          r;
      int          sel_pick;
      logic [3:0]  e_sel;
      logic [19:0] e_phys;
      int          e_lat;
      logic        e_err;
      logic        chg;
      sel_pick = $urandom_range(0, 9);
      if (sel_pick == 0)      a = 16'hFF00;
      else if (sel_pick < 3)  a = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
      else                    a = 16'($urandom);
      w    = 1'($urandom);
      wd   = 8'($urandom);
      seed = 8'($urandom);
      sel_pick = $urandom_range(0, 9);
      if (sel_pick < 6)       lat = $urandom_range(0, 3);
      else if (sel_pick == 6) lat = 15;
      else if (sel_pick == 7) lat = 16;
      else                    lat = $urandom_range(4, 14);
      r      = region(a);
      e_sel  = 4'b0;
      e_phys = 20'h0;
      e_err  = 1'b0;
      if (r == -2) begin
        e_lat = 1;
        if (w) bank_m = wd[3:0];
        else   di_m   = {4'h0, bank_m};
      end else if (r == -1) begin
        e_lat = 1;
        e_err = 1'b1;
        di_m  = 8'hFF;
      end else begin
        e_sel = 4'(1 << r);
        if (a >= 16'h4000 && a < 16'h8000) e_phys = 20'(int'(bank_m) * 16384 + (int'(a) - 'h4000));
        else                               e_phys = 20'(a);
        if (lat <= 15) begin
          e_lat = lat + 2;
          if (!w) di_m = seed + 8'(r);
        end else begin
          e_lat = 17;
          e_err = 1'b1;
          di_m  = 8'hFF;
        end
      end
      chg = (e_sel != 4'b0) && (e_lat >= 3) && ($urandom_range(0, 3) == 0);
      run_txn(a, w, wd, lat, seed, e_sel, e_phys, e_lat, e_err, di_m, bank_m, chg, 16'($urandom));
    end

    // Alternate map: unmapped low addresses and a first region that never answers.
    run_alt(16'h0800, 1'b0, 4'b0000, 1, 1'b1, 8'hFF);
    run_alt(16'h0000, 1'b1, 4'b0000, 1, 1'b1, 8'hFF);
    run_alt(16'h1000, 1'b0, 4'b0001, 17, 1'b1, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
